// File: rtl/judge_sequencer.sv
// rtl/judge_sequencer.sv - picture sequencer feeding the final-judge stage of the human-detection pipeline
module judge_sequencer #(
  parameter int STATE_DATAWIDTH = 4,
  parameter int IDLE_STATE      = 0,
  parameter int FETCH_STATE     = 1,
  parameter int INFER_STATE     = 2,
  parameter int JUDGE_STATE     = 11,
  parameter int REPORT_STATE    = 12,
  parameter int PICTURES        = 35,
  parameter int ALARM_HOLD      = 16,
  parameter int INFER_TIMEOUT   = 1023
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       frame_valid,
  output logic                       frame_ready,
  output logic                       infer_start,
  input  logic                       infer_done,
  input  logic [15:0]                logit_human,
  input  logic [15:0]                logit_nohuman,
  output logic [15:0]                human,
  output logic [15:0]                no_human,
  output logic [STATE_DATAWIDTH-1:0] State,
  input  logic                       bool,
  input  logic                       judge_done,
  input  logic                       all_done,
  output logic                       alarm,
  output logic                       detected,
  output logic [5:0]                 pic_count,
  output logic                       batch_done,
  output logic                       error,
  output logic                       busy
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_INFER, S_J1, S_J2, S_REPORT} state_t;

  // Last timer value still allowed to wait; infer_done missing here means timeout.
  localparam logic [9:0] TIMEOUT_LAST = 10'(INFER_TIMEOUT - 1);
  localparam logic [5:0] PIC_MAX      = 6'(PICTURES);
  localparam logic [7:0] HOLD         = 8'(ALARM_HOLD);

  state_t     state, state_nx;
  logic [9:0] infer_timer;
  logic [7:0] alarm_timer;
  logic [5:0] pic_next;
  logic       capture, judge_hit, count_en, batch_clear;

  assign busy  = (state != S_IDLE);
  assign alarm = (alarm_timer != 8'd0);

  // State register; reset aborts any batch straight back to idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state decode, State code and the single-cycle strobes.
  always_comb begin
    state_nx    = state;
    State       = STATE_DATAWIDTH'(IDLE_STATE);
    frame_ready = 1'b0;
    infer_start = 1'b0;
    error       = 1'b0;
    batch_done  = 1'b0;
    capture     = 1'b0;
    judge_hit   = 1'b0;
    count_en    = 1'b0;
    batch_clear = 1'b0;
    pic_next    = (pic_count == PIC_MAX) ? pic_count : pic_count + 6'd1;
    case (state)
      S_IDLE: begin
        if (start) begin
          batch_clear = 1'b1;
          state_nx    = S_FETCH;
        end
      end
      S_FETCH: begin
        State       = STATE_DATAWIDTH'(FETCH_STATE);
        frame_ready = 1'b1;
        if (frame_valid) state_nx = S_INFER;
      end
      S_INFER: begin
        State       = STATE_DATAWIDTH'(INFER_STATE);
        infer_start = (infer_timer == 10'd0);
        if (infer_done) begin
          capture  = 1'b1;
          state_nx = S_J1;
        end else if (infer_timer == TIMEOUT_LAST) begin
          error    = 1'b1;
          state_nx = S_IDLE;
        end
      end
      S_J1: begin
        State    = STATE_DATAWIDTH'(JUDGE_STATE);
        state_nx = S_J2;
      end
      S_J2: begin
        State = STATE_DATAWIDTH'(JUDGE_STATE);
        // A missing judge_done is flagged and its bool is discarded.
        if (!judge_done) error = 1'b1;
        else if (bool)   judge_hit = 1'b1;
        state_nx = S_REPORT;
      end
      S_REPORT: begin
        State    = STATE_DATAWIDTH'(REPORT_STATE);
        count_en = 1'b1;
        if (all_done || pic_next == PIC_MAX) begin
          batch_done = 1'b1;
          state_nx   = S_IDLE;
        end else begin
          state_nx = S_FETCH;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Inference wait timer: zero outside INFER so every entry starts fresh.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            infer_timer <= 10'd0;
    else if (state != S_INFER)          infer_timer <= 10'd0;
    else if (infer_timer != TIMEOUT_LAST) infer_timer <= infer_timer + 10'd1;
  end

  // Logit pair captured on infer_done and held for the judge unit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      human    <= 16'd0;
      no_human <= 16'd0;
    end else if (capture) begin
      human    <= logit_human;
      no_human <= logit_nohuman;
    end
  end

  // Per-batch bookkeeping: picture count saturates, detected is sticky.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pic_count <= 6'd0;
      detected  <= 1'b0;
    end else if (batch_clear) begin
      pic_count <= 6'd0;
      detected  <= 1'b0;
    end else begin
      if (count_en)  pic_count <= pic_next;
      if (judge_hit) detected  <= 1'b1;
    end
  end

  // Alarm hold timer; a fresh hit reloads rather than extends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        alarm_timer <= 8'd0;
    else if (judge_hit)             alarm_timer <= HOLD;
    else if (alarm_timer != 8'd0)   alarm_timer <= alarm_timer - 8'd1;
  end

endmodule

// File: tb/tb_judge_sequencer.sv
// tb/tb_judge_sequencer.sv - self-checking bench for judge_sequencer
module tb_judge_sequencer;

  localparam int PIC = 35;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, frame_valid = 1'b0, infer_done = 1'b0;
  logic [15:0] logit_human = 16'd0, logit_nohuman = 16'd0;
  logic        bool_i = 1'b0, judge_done = 1'b0, all_done = 1'b0;
  logic        frame_ready, infer_start, alarm, detected, batch_done, error, busy;
  logic [15:0] human, no_human;
  logic [3:0]  State;
  logic [5:0]  pic_count;

  typedef struct packed {logic is_batch; logic [5:0] count;} ev_t;
  ev_t        exp_q[$];
  ev_t        ev;
  int         checks = 0, errors = 0;
  logic [5:0] m_count = 6'd0;
  logic       m_detected = 1'b0;
  logic       alarm_seen = 1'b0;
  logic       pend = 1'b0;
  logic [5:0] pend_count = 6'd0;

  judge_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .infer_start(infer_start), .infer_done(infer_done), .logit_human(logit_human),
    .logit_nohuman(logit_nohuman), .human(human), .no_human(no_human), .State(State),
    .bool(bool_i), .judge_done(judge_done), .all_done(all_done), .alarm(alarm),
    .detected(detected), .pic_count(pic_count), .batch_done(batch_done), .error(error), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every batch_done / error pulse must match the next expected event.
  always @(negedge clk) begin
    if (alarm === 1'b1) alarm_seen = 1'b1;
    if (pend) begin
      pend = 1'b0;
      checks++;
      if (pic_count !== pend_count) begin
        errors++; $display("FAIL batch_count got %0d want %0d", pic_count, pend_count);
      end
    end
    if (batch_done === 1'b1 || error === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL unexpected_event got batch_done=%0b error=%0b want none", batch_done, error);
      end else begin
        ev = exp_q.pop_front();
        if (batch_done !== ev.is_batch || error !== !ev.is_batch) begin
          errors++; $display("FAIL event_kind got batch_done=%0b error=%0b want batch=%0b", batch_done, error, ev.is_batch);
        end
        if (ev.is_batch) begin
          pend = 1'b1; pend_count = ev.count;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic start_batch();
    start = 1'b1;
    @(negedge clk);
    checks++;
    if (State !== 4'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL pre_start_idle got state=%0d busy=%0b want 0 0", State, busy);
    end
    step();
    start = 1'b0; m_count = 6'd0; m_detected = 1'b0;
    @(negedge clk);
    checks++;
    if (State !== 4'd1 || pic_count !== 6'd0 || detected !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL start_clear got state=%0d cnt=%0d det=%0b busy=%0b want 1 0 0 1",
                         State, pic_count, detected, busy);
    end
    step();
  endtask

  task automatic run_pic(input logic b, input logic jd, input logic ad,
                         input logic [15:0] lh, input logic [15:0] ln, input int lat);
    int   w;
    logic last;
    w = 0;
    while (State !== 4'd1 && w < 20) begin step(); w++; end
    frame_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (frame_ready !== 1'b1 || State !== 4'd1) begin
      errors++; $display("FAIL fetch got ready=%0b state=%0d want 1 1", frame_ready, State);
    end
    step();
    frame_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (infer_start !== 1'b1 || State !== 4'd2) begin
      errors++; $display("FAIL infer_entry got start=%0b state=%0d want 1 2", infer_start, State);
    end
    repeat (lat) step();
    infer_done = 1'b1; logit_human = lh; logit_nohuman = ln;
    step();
    infer_done = 1'b0; logit_human = ~lh; logit_nohuman = ~ln;
    bool_i = b; judge_done = jd;
    @(negedge clk);
    checks++;
    if (State !== 4'd11 || human !== lh || no_human !== ln) begin
      errors++; $display("FAIL j1 got state=%0d h=%h nh=%h want 11 %h %h", State, human, no_human, lh, ln);
    end
    step();
    if (!jd) exp_q.push_back({1'b0, 6'd0});
    @(negedge clk);
    checks++;
    if (State !== 4'd11 || human !== lh || no_human !== ln) begin
      errors++; $display("FAIL j2 got state=%0d h=%h nh=%h want 11 %h %h", State, human, no_human, lh, ln);
    end
    step();
    bool_i = 1'b0; judge_done = 1'b0; all_done = ad;
    if (m_count < 6'(PIC)) m_count = m_count + 6'd1;
    last = ad || (m_count == 6'(PIC));
    if (last) exp_q.push_back({1'b1, m_count});
    if (b && jd) m_detected = 1'b1;
    @(negedge clk);
    checks++;
    if (State !== 4'd12 || (b && jd && alarm !== 1'b1)) begin
      errors++; $display("FAIL report got state=%0d alarm=%0b want 12 %0b", State, alarm, b && jd);
    end
    step();
    all_done = 1'b0;
    @(negedge clk);
    checks++;
    if (State !== (last ? 4'd0 : 4'd1) || pic_count !== m_count || detected !== m_detected ||
        (b && jd && alarm !== 1'b1)) begin
      errors++; $display("FAIL post_report got state=%0d cnt=%0d det=%0b alarm=%0b want %0d %0d %0b",
                         State, pic_count, detected, alarm, last ? 0 : 1, m_count, m_detected);
    end
    step();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({frame_ready, infer_start, human, no_human, State, alarm, detected, pic_count,
         batch_done, error, busy} !== '0) begin
      errors++; $display("FAIL reset_outputs got state=%0d cnt=%0d busy=%0b want all zero", State, pic_count, busy);
    end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_full_batch();
    alarm_seen = 1'b0;
    start_batch();
    for (int i = 0; i < PIC; i++) run_pic(1'b0, 1'b1, 1'b0, 16'h1000 + 16'(i), 16'h2000 + 16'(i), 5);
    repeat (4) step();
    @(negedge clk);
    checks++;
    if (pic_count !== 6'd35 || State !== 4'd0 || detected !== 1'b0 || alarm_seen !== 1'b0) begin
      errors++; $display("FAIL full_batch got cnt=%0d state=%0d det=%0b alarm_seen=%0b want 35 0 0 0",
                         pic_count, State, detected, alarm_seen);
    end
    step();
  endtask

  task automatic test_alarm();
    int n;
    start_batch();
    run_pic(1'b0, 1'b1, 1'b0, 16'h0101, 16'h0202, 5);
    run_pic(1'b0, 1'b1, 1'b0, 16'h0303, 16'h0404, 5);
    run_pic(1'b1, 1'b1, 1'b0, 16'h4400, 16'h3C00, 5);
    // REPORT and the following cycle were already checked high inside run_pic.
    n = 2;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (alarm !== 1'b1) break;
      n++;
      step();
    end
    step();
    checks++;
    if (n !== 16) begin
      errors++; $display("FAIL alarm_length got %0d want 16", n);
    end
    run_pic(1'b0, 1'b1, 1'b1, 16'h0505, 16'h0606, 3);
  endtask

  task automatic test_all_done();
    start_batch();
    for (int i = 1; i <= 6; i++) run_pic(1'b0, 1'b1, 1'b0, 16'(i * 77), 16'(i * 91), i);
    run_pic(1'b0, 1'b1, 1'b1, 16'hABCD, 16'h1234, 0);
    start_batch();
  endtask

  task automatic test_judge_missing();
    run_pic(1'b1, 1'b0, 1'b0, 16'h7777, 16'h8888, 2);
    @(negedge clk);
    checks++;
    if (detected !== 1'b0 || alarm !== 1'b0 || pic_count !== 6'd1) begin
      errors++; $display("FAIL judge_missing got det=%0b alarm=%0b cnt=%0d want 0 0 1", detected, alarm, pic_count);
    end
    step();
  endtask

  task automatic test_timeout();
    int n;
    frame_valid = 1'b1;
    @(negedge clk);
    step();
    frame_valid = 1'b0;
    exp_q.push_back({1'b0, 6'd0});
    n = 1;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      if (error === 1'b1) break;
      n++;
      step();
    end
    checks++;
    if (n !== 1023 || State !== 4'd2) begin
      errors++; $display("FAIL timeout_cycle got %0d state=%0d want 1023 2", n, State);
    end
    step();
    @(negedge clk);
    checks++;
    if (State !== 4'd0 || busy !== 1'b0 || pic_count !== 6'd1) begin
      errors++; $display("FAIL timeout_idle got state=%0d busy=%0b cnt=%0d want 0 0 1", State, busy, pic_count);
    end
    step();
  endtask

  task automatic test_reset_mid();
    start_batch();
    run_pic(1'b1, 1'b1, 1'b0, 16'h1111, 16'h2222, 1);
    frame_valid = 1'b1;
    @(negedge clk);
    step();
    frame_valid = 1'b0;
    infer_done = 1'b1; logit_human = 16'h5555; logit_nohuman = 16'h6666;
    step();
    infer_done = 1'b0;
    @(negedge clk);
    checks++;
    if (State !== 4'd11 || alarm !== 1'b1 || human !== 16'h5555) begin
      errors++; $display("FAIL pre_reset_j1 got state=%0d alarm=%0b h=%h want 11 1 5555", State, alarm, human);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({frame_ready, infer_start, human, no_human, State, alarm, detected, pic_count,
         batch_done, error, busy} !== '0) begin
      errors++; $display("FAIL mid_reset got state=%0d alarm=%0b cnt=%0d h=%h want all zero",
                         State, alarm, pic_count, human);
    end
    m_count = 6'd0; m_detected = 1'b0;
    start = 1'b1;
    step();
    @(negedge clk);
    checks++;
    if (State !== 4'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL start_in_reset got state=%0d busy=%0b want 0 0", State, busy);
    end
    step();
    rst = 1'b0; start = 1'b0;
    step();
    start_batch();
    run_pic(1'b0, 1'b1, 1'b0, 16'h0A0A, 16'h0B0B, 2);
    start = 1'b1;
    repeat (3) step();
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (State !== 4'd1 || pic_count !== 6'd1) begin
      errors++; $display("FAIL start_ignored got state=%0d cnt=%0d want 1 1", State, pic_count);
    end
    step();
    run_pic(1'b0, 1'b1, 1'b1, 16'h0C0C, 16'h0D0D, 2);
  endtask

  initial begin
    test_reset();
    test_full_batch();
    test_alarm();
    test_all_done();
    test_judge_missing();
    test_timeout();
    test_reset_mid();
    repeat (3) step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL missing_events got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
